// File: rtl/mdu_seq.sv
// Iterative RV M-extension multiply/divide unit beside the EXE-stage ALU.
// It stalls EXE through exe_hazard and presents one result per accepted op.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            exe_stall,
  input  logic            abort,
  output logic            exe_hazard,
  output logic [XLEN-1:0] res,
  output logic            res_valid
);

  // state | meaning
  // IDLE  | waiting for an M-op in EXE
  // BUSY  | one shift-add / restoring-divide step per cycle
  // DONE  | result presented, held while EXE is stalled
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(XLEN + 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   hi, lo, b_q;
  logic [2:0]        op_q;
  logic              neg_q;

  logic              s1_signed, s2_signed, is_div, a_neg, b_neg, neg_in;
  logic              div_zero, div_ovf, accept;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quo_c, rem_c;

  always_comb begin
    is_div    = op[2];
    s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg     = s1_signed & src1[XLEN-1];
    b_neg     = s2_signed & src2[XLEN-1];
    a_abs     = a_neg ? -src1 : src1;
    b_abs     = b_neg ? -src2 : src2;
    // remainder sign follows the dividend, everything else the sign XOR
    neg_in    = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div & (src2 == '0);
    div_ovf   = is_div & ~op[0] & (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&src2);
    accept    = (state == IDLE) & req & ~abort;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = (div_zero | div_ovf) ? DONE : BUSY;
      BUSY: begin
        if (!req)                  state_nx = IDLE;
        else if (cnt == CW'(1))    state_nx = DONE;
      end
      DONE: if (!exe_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      b_q  <= b_abs;
      cnt  <= CW'(XLEN);
      // special divide cases are preloaded as final, already-signed values
      if (div_zero) begin
        hi    <= src1;
        lo    <= '1;
        neg_q <= 1'b0;
      end else if (div_ovf) begin
        hi    <= '0;
        lo    <= src1;
        neg_q <= 1'b0;
      end else begin
        hi    <= '0;
        lo    <= a_abs;
        neg_q <= neg_in;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi <= div_diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod_c     = neg_q ? -{hi, lo} : {hi, lo};
    quo_c      = neg_q ? -lo : lo;
    rem_c      = neg_q ? -hi : hi;
    exe_hazard = req & ~abort & (state != DONE);
    res        = '0;
    res_valid  = 1'b0;
    if (state == DONE) begin
      res_valid = 1'b1;
      case (op_q)
        3'd0:             res = prod_c[XLEN-1:0];
        3'd1, 3'd2, 3'd3: res = prod_c[2*XLEN-1:XLEN];
        3'd4, 3'd5:       res = quo_c;
        default:          res = rem_c;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus random ops against
// an arithmetic reference model of the RV M-extension results.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        exe_stall = 1'b0;
  logic        abort = 1'b0;
  logic        exe_hazard;
  logic [31:0] res;
  logic        res_valid;

  int compared = 0;
  int mismatched = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .req(req), .op(op), .src1(src1), .src2(src2),
    .exe_stall(exe_stall), .abort(abort), .exe_hazard(exe_hazard),
    .res(res), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_hz(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one op, count hazard cycles, check result; stall_n extra DONE cycles
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int stall_n);
    logic [31:0] exp;
    int          hz;
    bit          got;
    exp = ref_res(o, a, b);
    hz  = 0;
    got = 0;
    @(posedge clk); #1;
    req = 1'b1; op = o; src1 = a; src2 = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) got = 1;
      else begin
        if (exe_hazard === 1'b1) hz++;
        @(posedge clk); #1;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("res op%0d %h,%h", o, a, b), res, exp);
      chk($sformatf("hazard_cycles op%0d", o), 32'(hz), 32'(ref_hz(o, a, b)));
      chk("done_hazard", 32'(exe_hazard), 32'd0);
      if (stall_n > 0) exe_stall = 1'b1;
      for (int j = 1; j <= stall_n; j++) begin
        @(posedge clk); #1;
        if (j == stall_n) exe_stall = 1'b0;
        @(negedge clk);
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_res", res, exp);
      end
    end
  endtask

  task automatic idle_chk();
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(res_valid), 32'd0);
    chk("idle_res", res, 32'd0);
    chk("idle_hazard", 32'(exe_hazard), 32'd0);
  endtask

  initial begin
    int rv_seen;
    logic [2:0] ro;
    #3;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_hazard", 32'(exe_hazard), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    idle_chk();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); idle_chk();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); idle_chk();
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0); idle_chk();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);         idle_chk();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);         idle_chk();
    run_op(3'd5, 32'd100, 32'd7, 0);               idle_chk();
    run_op(3'd7, 32'd100, 32'd7, 0);               idle_chk();
    run_op(3'd4, 32'd5, 32'd0, 0);                 idle_chk();
    run_op(3'd6, 32'd5, 32'd0, 0);                 idle_chk();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0); idle_chk();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0); idle_chk();

    // abort in the 10th BUSY cycle of a DIV
    @(posedge clk); #1;
    req = 1'b1; op = 3'd4; src1 = 32'd1000; src2 = 32'd7;
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_hazard", 32'(exe_hazard), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; req = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || exe_hazard !== 1'b0) rv_seen++;
    end
    chk("abort_no_result", 32'(rv_seen), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 0);
    idle_chk();

    // DONE held by exe_stall, then a back-to-back op
    run_op(3'd5, 32'd1234567, 32'd89, 3);
    run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    idle_chk();

    // async reset mid-BUSY
    @(posedge clk); #1;
    req = 1'b1; op = 3'd3; src1 = 32'hFFFF_0000; src2 = 32'h0001_FFFF;
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0; req = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_res", res, 32'd0);
    chk("arst_hazard", 32'(exe_hazard), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 0);
    idle_chk();

    // random ops, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      run_op(ro, pick(), pick(), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 0) idle_chk();
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
